md_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the MIPS pipeline's EX stage.
- Sits beside the combinational ALU.
- Accepts one operation per start pulse and holds busy for a fixed, parameter-set latency.
- The pipeline stalls any mult/div/mfhi/mflo/mthi/mtlo while busy is high.

---
 rtl/md_unit.sv | 126 ++++++++++++
 tb/tb_md_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Optional accumulate ops (madd/maddu/msub/msubu) are built only when MD_MADD_EN is defined.
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] indata1,
    input  logic [WIDTH-1:0] indata2,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // start is a one-cycle request sampled only in IDLE; there is no ready,
    // busy is the sole backpressure and the pipeline must hold off while it is high.
    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   q_s, r_s, q_u, r_u;
    logic [WIDTH-1:0]   calc_hi, calc_lo;
    logic               op_valid, op_div;

    always_comb begin
        prod_s = $signed({{WIDTH{indata1[WIDTH-1]}}, indata1}) *
                 $signed({{WIDTH{indata2[WIDTH-1]}}, indata2});
        prod_u = {{WIDTH{1'b0}}, indata1} * {{WIDTH{1'b0}}, indata2};
    end

    // Divide by zero keeps the defaults: quotient all ones, remainder = dividend.
    always_comb begin
        q_s = '1;
        r_s = indata1;
        q_u = '1;
        r_u = indata1;
        if (indata2 != '0) begin
            q_u = indata1 / indata2;
            r_u = indata1 % indata2;
            if (indata1 == MIN_VAL && indata2 == '1) begin
                q_s = MIN_VAL;
                r_s = '0;
            end else begin
                q_s = $signed(indata1) / $signed(indata2);
                r_s = $signed(indata1) % $signed(indata2);
            end
        end
    end

    always_comb begin
        calc_hi = '0;
        calc_lo = '0;
        case (mdop)
            3'd0: {calc_hi, calc_lo} = prod_s;
            3'd1: {calc_hi, calc_lo} = prod_u;
            3'd2: {calc_hi, calc_lo} = {r_s, q_s};
            3'd3: {calc_hi, calc_lo} = {r_u, q_u};
`ifdef MD_MADD_EN
            3'd4: {calc_hi, calc_lo} = {hi, lo} + prod_s;
            3'd5: {calc_hi, calc_lo} = {hi, lo} + prod_u;
            3'd6: {calc_hi, calc_lo} = {hi, lo} - prod_s;
            3'd7: {calc_hi, calc_lo} = {hi, lo} - prod_u;
`endif
            default: ;
        endcase
    end

`ifdef MD_MADD_EN
    assign op_valid = 1'b1;
`else
    assign op_valid = ~mdop[2];
`endif
    assign op_div = (mdop == 3'd2) || (mdop == 3'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            count  <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && op_valid) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        count  <= op_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        res_hi <= calc_hi;
                        res_lo <= calc_lo;
                    end else if (hilo_we) begin
                        if (hilo_sel) hi <= indata1;
                        else          lo <= indata1;
                    end
                end
                RUN: begin
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                        hi    <= res_hi;
                        lo    <= res_lo;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed vectors checked with immediate assertions.
module tb_md_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] indata1;
    logic [31:0] indata2;
    logic        hilo_we;
    logic        hilo_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int errors  = 0;
    int cyc;

    md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mdop(mdop),
        .indata1(indata1), .indata2(indata2), .hilo_we(hilo_we),
        .hilo_sel(hilo_sel), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change at negedge; the start edge is the posedge in between.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic we);
        @(negedge clk);
        start    = 1'b1;
        mdop     = op;
        indata1  = a;
        indata2  = b;
        hilo_we  = we;
        hilo_sel = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        hilo_we = 1'b0;
        indata1 = $urandom;
        indata2 = $urandom;
    endtask

    // Counts negedges (from the current one) at which busy is high.
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_hilo(input logic sel, input logic [31:0] val);
        @(negedge clk);
        hilo_we  = 1'b1;
        hilo_sel = sel;
        indata1  = val;
        @(negedge clk);
        hilo_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mdop = '0; indata1 = '0; indata2 = '0;
        hilo_we = 1'b0; hilo_sel = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        start_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_done(cyc);
        check("mult_cycles", cyc, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(cyc);
        check("multu_cycles", cyc, 32'd5);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        start_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done(cyc);
        check("div_cycles", cyc, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        start_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
        wait_done(cyc);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'h0000_0001);

        start_op(3'd3, 32'd7, 32'd0, 1'b0);
        wait_done(cyc);
        check("divu0_cycles", cyc, 32'd10);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'h0000_0007);

        start_op(3'd2, 32'hFFFF_FFFB, 32'd0, 1'b0);
        wait_done(cyc);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'hFFFF_FFFB);

        start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(cyc);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'h0000_0000);

        start_op(3'd3, 32'd100, 32'd7, 1'b0);
        wait_done(cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        write_hilo(1'b1, 32'hCAFE_F00D);
        check("mthi_hi", hi, 32'hCAFE_F00D);
        check("mthi_lo_kept", lo, 32'd14);
        write_hilo(1'b0, 32'h1234_5678);
        check("mtlo_lo", lo, 32'h1234_5678);
        check("mtlo_hi_kept", hi, 32'hCAFE_F00D);

        // start and hilo_we both pulsed while busy must be ignored
        start_op(3'd0, 32'd3, 32'd4, 1'b0);
        start    = 1'b1;
        mdop     = 3'd2;
        indata1  = 32'd1;
        indata2  = 32'd1;
        hilo_we  = 1'b1;
        hilo_sel = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        hilo_we = 1'b0;
        indata1 = 32'h1234;
        wait_done(cyc);
        check("busy_ign_cycles", cyc, 32'd4);
        check("busy_ign_hi", hi, 32'd0);
        check("busy_ign_lo", lo, 32'd12);

        start_op(3'd0, 32'd5, 32'd6, 1'b1);
        wait_done(cyc);
        check("start_wins_cycles", cyc, 32'd5);
        check("start_wins_lo", lo, 32'd30);
        check("start_wins_hi", hi, 32'd0);

        write_hilo(1'b1, 32'h0000_ABCD);
        start_op(3'd2, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_after_busy", {31'd0, busy}, 32'd0);
        check("rst_after_hi", hi, 32'd0);
        check("rst_after_lo", lo, 32'd0);

`ifdef MD_MADD_EN
        write_hilo(1'b1, 32'd0);
        write_hilo(1'b0, 32'hFFFF_FFFF);
        start_op(3'd5, 32'd1, 32'd1, 1'b0);
        wait_done(cyc);
        check("maddu_cycles", cyc, 32'd5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
        start_op(3'd6, 32'd2, 32'd3, 1'b0);
        wait_done(cyc);
        check("msub_hi", hi, 32'd0);
        check("msub_lo", lo, 32'hFFFF_FFFA);
`else
        write_hilo(1'b1, 32'h11);
        write_hilo(1'b0, 32'h22);
        start_op(3'd4, 32'd2, 32'd3, 1'b0);
        check("nomadd_busy", {31'd0, busy}, 32'd0);
        start_op(3'd7, 32'd2, 32'd3, 1'b0);
        repeat (6) @(negedge clk);
        check("nomadd_busy_late", {31'd0, busy}, 32'd0);
        check("nomadd_hi", hi, 32'h11);
        check("nomadd_lo", lo, 32'h22);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
